sub_64bit_pipe: RTL and testbench
=================================

Name: sub_64bit_pipe

Overview:
Pipelined 64-bit subtractor; the inverse operation of the team's ripple-carry adder. Computes d = a - b - bin as a + ~b + ~bin over a chain of full_adder cells. The chain is split into STAGES registered slices so the long carry/borrow ripple is broken across cycles.
Valid/ready handshake on both sides. Full throughput of one operation per cycle. Sits in the arithmetic datapath wherever a wide difference or compare is needed at clock rate.

Parameters:
WIDTH, 64, operand/result width in bits
STAGES, 4, pipeline depth; must divide WIDTH evenly; slice width SLICE = WIDTH/STAGES

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand set present
in_ready  output  1  block accepts operands this cycle
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
bin  input  1  borrow in
out_valid  output  1  result present
out_ready  input  1  consumer accepts result this cycle
d  output  WIDTH  difference, (a - b - bin) mod 2^WIDTH
bout  output  1  borrow out; 1 when unsigned a < b + bin
ovf  output  1  two's-complement signed overflow

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low (rst_n).
- Reset values: all stage valid bits clear; out_valid=0, d=0, bout=0, ovf=0; in_ready=0 while rst_n=0.
- Transfers: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Stage k (0..STAGES-1): adds slice k of a and ~b using the carry registered by stage k-1. Stage 0 uses carry-in = ~bin.
  - Higher operand slices are skewed forward through the stages.
  - Completed lower result slices travel along with the operation.
- Last stage registers the outputs:
  - d = concatenated result slices.
  - bout = ~carry_out.
  - ovf = (a[MSB] != b[MSB]) & (d[MSB] != a[MSB]).
- Latency: an operation accepted at edge N is presented with out_valid=1 after edge N+STAGES, assuming no stall.
- Advance rule: stage k loads from stage k-1 when stage k is empty or is itself advancing. The last stage advances when out_valid=0 or out_ready=1.
- in_ready = ~stage0_valid | stage0_advancing. This is combinational from out_ready through the valid chain; no extra register.
- Stall: while out_valid=1 and out_ready=0, d/bout/ovf hold stable. A full pipeline deasserts in_ready; no operation is lost or duplicated.
- Simultaneous accept and emit in the same cycle with a full pipeline: legal, throughput is kept.
- Ordering: strictly FIFO; results appear in acceptance order.
- Reset mid-operation: all in-flight operations are discarded immediately; out_valid drops asynchronously.
- Inputs are ignored when in_ready=0.

Optional Feature:
Macro SUB64_ADD_MODE_EN.
- Defined:
  - Extra input port op (1 bit), captured with the operands and carried with the operation.
  - op=1 computes a + b + bin: b is not inverted, carry-in = bin, bout = carry_out (carry semantics), ovf = additive signed overflow.
  - op=0 computes the subtract exactly as above.
- Undefined: no op port; subtract only.

Decomposition:
- Package sub64_pkg:
  - WIDTH/STAGES defaults, localparam SLICE.
  - Stage-register typedef {valid, carry, result slices, remaining operand slices, op}.
  - Assertion that STAGES divides WIDTH.
- Sub-module sub_slice:
  - Combinational SLICE-bit ripple of the existing full_adder cells, with a per-bit b-invert controlled by mode.
  - One instance per stage.

Test Plan:
1. a=5, b=3, bin=0, out_ready=1 -> d=2, bout=0, ovf=0, out_valid exactly 4 cycles after acceptance.
2. a=0, b=1, bin=0 -> d=0xFFFF_FFFF_FFFF_FFFF, bout=1, ovf=0; a=7, b=7, bin=1 -> d=all-ones, bout=1.
3. a=0x8000_0000_0000_0000, b=1 -> d=0x7FFF_FFFF_FFFF_FFFF, ovf=1, bout=0.
4. Cross-slice borrow: a=0x0001_0000_0000_0000, b=1 -> d=0x0000_FFFF_FFFF_FFFF, bout=0.
5. Backpressure: stream 8 random operations back-to-back, out_ready=0 on cycles 3-8 -> all 8 results match the model in order, no duplicates, in_ready=0 while full, d stable during the stall. Then 1/cycle throughput resumes.
6. Reset: assert rst_n=0 with 3 operations in flight -> out_valid=0 immediately and outputs zero. After release, nothing stale is emitted; a new a=10, b=4 yields d=6.
   With SUB64_ADD_MODE_EN: op=1, a=all-ones, b=1 -> d=0, bout=1.

Source files
------------

// File: rtl/sub64_pkg.sv
// ----------------------------------------------------------------------------
// sub64_pkg
// Shared constants, the per-stage pipeline record and the signed-overflow
// helper for the pipelined 64-bit subtractor (sub_64bit_pipe).
//   DEF_WIDTH / DEF_STAGES : default operand width and pipeline depth
//   SLICE                  : bits resolved per stage
//   STAGES_DIVIDE_OK       : 1 when the depth splits the width evenly
//   stage_t                : one stage register (valid, carry, op, partial
//                            result, operand slices not yet consumed)
// ----------------------------------------------------------------------------
package sub64_pkg;

    localparam int DEF_WIDTH  = 64;
    localparam int DEF_STAGES = 4;
    localparam int SLICE      = DEF_WIDTH / DEF_STAGES;

    // Checked by the top level at elaboration.
    localparam bit STAGES_DIVIDE_OK = ((DEF_WIDTH % DEF_STAGES) == 0);

    // Operands are shifted down by SLICE every stage, so the slice a stage
    // works on is always bits [SLICE-1:0]. Result slices are shifted in
    // from the top, so after the last stage res holds the full difference.
    typedef struct packed {
        logic                 valid;
        logic                 carry;
        logic                 op;
        logic [DEF_WIDTH-1:0] res;
        logic [DEF_WIDTH-1:0] a_rem;
        logic [DEF_WIDTH-1:0] b_rem;
    } stage_t;

    // Signed overflow of a +/- b: the effective second operand has the same
    // sign as a, and the result sign differs from a.
    function automatic logic calc_ovf(
        input logic a_msb,
        input logic b_msb,
        input logic d_msb,
        input logic add_op
    );
        logic b_eff;
        b_eff = add_op ? b_msb : ~b_msb;
        return (a_msb == b_eff) && (d_msb != a_msb);
    endfunction

endpackage

// File: rtl/full_adder.sv
// ----------------------------------------------------------------------------
// full_adder
// One-bit full adder cell used to build the ripple slices.
//   a, b, cin : addend bits and carry in
//   sum, cout : sum bit and carry out
// ----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/sub_slice.sv
// ----------------------------------------------------------------------------
// sub_slice
// Combinational SLICE_W-bit ripple of full_adder cells computing
// a + (mode ? b : ~b) + cin. One instance per pipeline stage.
//   a, b  : operand slices
//   cin   : carry into bit 0
//   mode  : 1 = add (b as is), 0 = subtract (b inverted)
//   sum   : result slice
//   cout  : carry out of the top bit
// ----------------------------------------------------------------------------
module sub_slice
    import sub64_pkg::*;
#(
    parameter int SLICE_W = SLICE
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    input  logic               mode,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    logic [SLICE_W-1:0] b_eff_s;

    assign b_eff_s = mode ? b : ~b;

    // Each bit keeps its own carry nets so the chain is a set of distinct
    // signals rather than one vector feeding back on itself.
    for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
        logic ci_s;
        logic co_s;

        if (i == 0) begin : g_first
            assign ci_s = cin;
        end else begin : g_rest
            assign ci_s = g_bit[i-1].co_s;
        end

        full_adder u_fa (
            .a    (a[i]),
            .b    (b_eff_s[i]),
            .cin  (ci_s),
            .sum  (sum[i]),
            .cout (co_s)
        );
    end

    assign cout = g_bit[SLICE_W-1].co_s;

endmodule

// File: rtl/sub_64bit_pipe.sv
// ----------------------------------------------------------------------------
// sub_64bit_pipe
// Pipelined WIDTH-bit subtractor d = a - b - bin, computed as a + ~b + ~bin
// over STAGES registered ripple slices, with valid/ready on both sides and
// one operation per cycle throughput. Results appear STAGES edges after
// acceptance, in acceptance order.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (in_ready combinational)
//   a, b, bin            : minuend, subtrahend, borrow in
//   op                   : 1 = a + b + bin (only with SUB64_ADD_MODE_EN)
//   out_valid / out_ready: result handshake
//   d, bout, ovf         : difference, borrow out, signed overflow
// Optional feature macro: SUB64_ADD_MODE_EN adds the op port (add mode).
// ----------------------------------------------------------------------------
module sub_64bit_pipe
    import sub64_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
`ifdef SUB64_ADD_MODE_EN
    input  logic             op,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    localparam int LAST = STAGES - 1;

    if (!STAGES_DIVIDE_OK || (WIDTH != DEF_WIDTH) || (STAGES != DEF_STAGES)) begin : g_bad_cfg
        $error("sub_64bit_pipe: WIDTH/STAGES must match sub64_pkg and divide evenly");
    end

    stage_t             st_r     [STAGES];
    stage_t             nxt_s    [STAGES];
    stage_t             in_stage_s;
    logic [SLICE-1:0]   sum_s    [STAGES];
    logic               cout_s   [STAGES];
    logic [STAGES-1:0]  accept_s;
    logic               out_accept_s;
    logic               op_s;

    logic               out_valid_r;
    logic [WIDTH-1:0]   d_r;
    logic               bout_r;
    logic               ovf_r;

`ifdef SUB64_ADD_MODE_EN
    assign op_s = op;
`else
    assign op_s = 1'b0;
`endif

    // One ripple slice per stage, always on the lowest remaining slice.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        sub_slice #(.SLICE_W(SLICE)) u_slice (
            .a    (st_r[k].a_rem[SLICE-1:0]),
            .b    (st_r[k].b_rem[SLICE-1:0]),
            .cin  (st_r[k].carry),
            .mode (st_r[k].op),
            .sum  (sum_s[k]),
            .cout (cout_s[k])
        );
    end

    // Build the record each stage hands to the next one.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            nxt_s[k]       = st_r[k];
            nxt_s[k].carry = cout_s[k];
            nxt_s[k].res   = {sum_s[k], st_r[k].res[DEF_WIDTH-1:SLICE]};
            nxt_s[k].a_rem = st_r[k].a_rem >> SLICE;
            nxt_s[k].b_rem = st_r[k].b_rem >> SLICE;
        end
    end

    // Capture a new operation; subtract injects ~bin, add injects bin.
    always_comb begin
        in_stage_s       = '0;
        in_stage_s.valid = in_valid;
        in_stage_s.op    = op_s;
        in_stage_s.carry = op_s ? bin : ~bin;
        in_stage_s.a_rem = a;
        in_stage_s.b_rem = b;
    end

    // Walk from the output back: a stage may load when it is empty or its
    // own contents are moving on, which reduces to ~valid | downstream_ok.
    always_comb begin
        logic down_ok_s;
        down_ok_s = ~out_valid_r | out_ready;
        accept_s  = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            accept_s[k] = ~st_r[k].valid | down_ok_s;
            down_ok_s   = accept_s[k];
        end
    end

    assign out_accept_s = ~out_valid_r | out_ready;
    assign in_ready     = rst_n & accept_s[0];

    // Stage registers: load from the previous stage (or the inputs) when allowed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                st_r[k] <= '0;
            end
        end else begin
            if (accept_s[0]) begin
                st_r[0] <= in_stage_s;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (accept_s[k]) begin
                    st_r[k] <= nxt_s[k-1];
                end
            end
        end
    end

    // Output register: finishes the last slice; holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            d_r         <= '0;
            bout_r      <= 1'b0;
            ovf_r       <= 1'b0;
        end else if (out_accept_s) begin
            out_valid_r <= st_r[LAST].valid;
            if (st_r[LAST].valid) begin
                d_r    <= {sum_s[LAST], st_r[LAST].res[DEF_WIDTH-1:SLICE]};
                bout_r <= st_r[LAST].op ? cout_s[LAST] : ~cout_s[LAST];
                ovf_r  <= calc_ovf(st_r[LAST].a_rem[SLICE-1],
                                   st_r[LAST].b_rem[SLICE-1],
                                   sum_s[LAST][SLICE-1],
                                   st_r[LAST].op);
            end
        end
    end

    assign out_valid = out_valid_r;
    assign d         = d_r;
    assign bout      = bout_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_sub_64bit_pipe.sv
// ----------------------------------------------------------------------------
// tb_sub_64bit_pipe
// Self-checking bench for sub_64bit_pipe: directed vector table, backpressure
// stream, reset with operations in flight, and a randomized handshake run
// checked against an arithmetic reference model through an in-order queue.
// ----------------------------------------------------------------------------
module tb_sub_64bit_pipe;

    localparam int W   = 64;
    localparam int STG = 4;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a         = '0;
    logic [W-1:0]  b         = '0;
    logic          bin       = 1'b0;
    logic          op        = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  d;
    logic          bout;
    logic          ovf;

    always #5 clk = ~clk;

    sub_64bit_pipe #(.WIDTH(W), .STAGES(STG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
`ifdef SUB64_ADD_MODE_EN
        .op        (op),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .d         (d),
        .bout      (bout),
        .ovf       (ovf)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic         op;
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } vec_t;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        int           acc_edge;
        bit           chk_lat;
    } exp_t;

    exp_t         sb[$];
    exp_t         pend;
    int           n_vec    = 0;
    int           n_err    = 0;
    int           edge_cnt = 0;
    int           n_acc    = 0;
    bit           stall_prev = 1'b0;
    logic [W-1:0] stall_d;
    logic         stall_bo;
    logic         stall_ov;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic on the operand values.
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic mbin, input logic mop,
                                  output logic [W-1:0] md, output logic mbo, output logic mov);
        logic signed [W+1:0] s;
        logic signed [W+1:0] sa;
        logic signed [W+1:0] sb_v;
        logic signed [W+1:0] sc;
        sa   = $signed({{2{ma[W-1]}}, ma});
        sb_v = $signed({{2{mb[W-1]}}, mb});
        sc   = $signed({{(W+1){1'b0}}, mbin});
        if (mop) begin
            md  = ma + mb + {{(W-1){1'b0}}, mbin};
            mbo = (({1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mbin}) > {1'b0, {W{1'b1}}});
            s   = sa + sb_v + sc;
        end else begin
            md  = ma - mb - {{(W-1){1'b0}}, mbin};
            mbo = ({1'b0, ma} < ({1'b0, mb} + {{W{1'b0}}, mbin}));
            s   = sa - sb_v - sc;
        end
        mov = (s > 66'sd9223372036854775807) || (s < -66'sd9223372036854775808);
    endfunction

    function automatic logic rand_op();
`ifdef SUB64_ADD_MODE_EN
        return 1'($urandom_range(0, 1));
`else
        return 1'b0;
`endif
    endfunction

    task automatic set_exp(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                           input logic top, input logic [W-1:0] ed, input logic ebo,
                           input logic eov, input bit lat);
        in_valid     = 1'b1;
        a            = ta;
        b            = tb;
        bin          = tbin;
        op           = top;
        pend.d       = ed;
        pend.bo      = ebo;
        pend.ov      = eov;
        pend.chk_lat = lat;
    endtask

    task automatic set_rand(input bit lat);
        logic [W-1:0] ta;
        logic [W-1:0] tb;
        logic [W-1:0] md;
        logic         tbin;
        logic         top;
        logic         mbo;
        logic         mov;
        ta   = {$urandom, $urandom};
        tb   = {$urandom, $urandom};
        tbin = 1'($urandom_range(0, 1));
        top  = rand_op();
        model(ta, tb, tbin, top, md, mbo, mov);
        set_exp(ta, tb, tbin, top, md, mbo, mov, lat);
    endtask

    // Observe one cycle (inputs already driven at the falling edge), then
    // advance across the next rising edge back to the falling edge.
    task automatic cycle();
        exp_t e;
        #1;
        if (rst_n) begin
            if (stall_prev) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_d", d, stall_d);
                check("stall_bout", 64'(bout), 64'(stall_bo));
                check("stall_ovf", 64'(ovf), 64'(stall_ov));
            end
            if ((sb.size() == STG + 1) && !out_ready) begin
                check("full_in_ready", 64'(in_ready), 64'd0);
            end
            if (in_valid && in_ready) begin
                pend.acc_edge = edge_cnt + 1;
                sb.push_back(pend);
                n_acc++;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: got d=%h, expected no result", d);
                end else begin
                    e = sb.pop_front();
                    check("d", d, e.d);
                    check("bout", 64'(bout), 64'(e.bo));
                    check("ovf", 64'(ovf), 64'(e.ov));
                    if (e.chk_lat) begin
                        check("latency", 64'(edge_cnt - e.acc_edge), 64'(STG));
                    end
                end
            end
            stall_prev = out_valid && !out_ready;
            stall_d    = d;
            stall_bo   = bout;
            stall_ov   = ovf;
        end
        @(posedge clk);
        edge_cnt++;
        @(negedge clk);
    endtask

    task automatic drain();
        int guard;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard     = 0;
        while ((sb.size() > 0) && (guard < 60)) begin
            cycle();
            guard++;
        end
        if (sb.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d results outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    vec_t vecs[$];

    initial begin
        int sent_base;

        // Directed vectors: {a, b, bin, op, d, bout, ovf}.
        vecs.push_back('{64'd5, 64'd3, 1'b0, 1'b0, 64'd2, 1'b0, 1'b0});
        vecs.push_back('{64'd0, 64'd1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0});
        vecs.push_back('{64'd7, 64'd7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0});
        vecs.push_back('{64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1});
        vecs.push_back('{64'h0001_0000_0000_0000, 64'd1, 1'b0, 1'b0, 64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b0});
        vecs.push_back('{64'h0000_0000_0001_0000, 64'd1, 1'b0, 1'b0, 64'h0000_0000_0000_FFFF, 1'b0, 1'b0});
        vecs.push_back('{64'd0, 64'd0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0});
        vecs.push_back('{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b1});
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'd0, 1'b0, 1'b0});
`ifdef SUB64_ADD_MODE_EN
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 64'd0, 1'b1, 1'b0});
        vecs.push_back('{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b1});
`endif

        // Reset state.
        @(negedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_d", d, 64'd0);
        check("rst_bout", 64'(bout), 64'd0);
        check("rst_ovf", 64'(ovf), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // Directed table, back-to-back, latency checked on every result.
        for (int i = 0; i < vecs.size(); i++) begin
            set_exp(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].op,
                    vecs[i].d, vecs[i].bo, vecs[i].ov, 1'b1);
            cycle();
        end
        drain();

        // Backpressure: continuous stream, consumer stalls cycles 3..8.
        sent_base = n_acc;
        for (int c = 1; c <= 20; c++) begin
            out_ready = ((c >= 3) && (c <= 8)) ? 1'b0 : 1'b1;
            if ((n_acc - sent_base) < 14) begin
                set_rand(1'b0);
            end else begin
                in_valid = 1'b0;
            end
            if ((c >= 9) && (c <= 16)) begin
                #1;
                check("tput_in_ready", 64'(in_ready), 64'd1);
                check("tput_out_valid", 64'(out_valid), 64'd1);
            end
            cycle();
        end
        drain();

        // Random handshake traffic.
        for (int c = 0; c < 400; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0) begin
                set_rand(1'b0);
            end else begin
                in_valid = 1'b0;
            end
            cycle();
        end
        drain();

        // Reset with operations in flight and a stalled result on the output.
        out_ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            set_exp(64'd100 + 64'(c), 64'd1, 1'b0, 1'b0, 64'd99 + 64'(c), 1'b0, 1'b0, 1'b0);
            cycle();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_d", d, 64'd0);
        check("mid_rst_bout", 64'(bout), 64'd0);
        check("mid_rst_ovf", 64'(ovf), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        sb.delete();
        stall_prev = 1'b0;
        @(posedge clk);
        edge_cnt++;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            check("post_rst_idle", 64'(out_valid), 64'd0);
            cycle();
        end
        set_exp(64'd10, 64'd4, 1'b0, 1'b0, 64'd6, 1'b0, 1'b0, 1'b1);
        cycle();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
